// File: rtl/cc_branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : cc_branch_unit_if
// Brief   : Datapath/handshake bundle between the LC-3 control path and the
//           condition-code / branch resolution stage.
// Revision: 1.0  initial release
// ============================================================================
interface cc_branch_unit_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] BUS;
    logic [DATA_W-1:0] IR;
    logic [DATA_W-1:0] PC;
    logic              LD_CC;
    logic              LD_BEN;
    logic              br_start;
    logic              br_ack;
    logic              N;
    logic              Z;
    logic              P;
    logic              BEN;
    logic              br_busy;
    logic              pc_valid;
    logic [DATA_W-1:0] pc_next;
    logic              br_taken;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output BUS, IR, PC, LD_CC, LD_BEN, br_start, br_ack,
        input  N, Z, P, BEN, br_busy, pc_valid, pc_next, br_taken, taken_count
    );

    modport slave (
        input  BUS, IR, PC, LD_CC, LD_BEN, br_start, br_ack,
        output N, Z, P, BEN, br_busy, pc_valid, pc_next, br_taken, taken_count
    );
endinterface
`default_nettype wire

// File: rtl/cc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module  : cc_branch_unit
// Brief   : LC-3 N/Z/P and BEN registers plus a small BR resolver that
//           produces the next PC over a valid/ack handshake.
// Revision: 1.0  initial release
// ============================================================================
module cc_branch_unit #(
    parameter int         DATA_W    = 16,
    parameter int         OFFSET_W  = 9,
    parameter int         CNT_W     = 16,
    parameter logic [2:0] NZP_RESET = 3'b010
) (
    input  wire               clk,
    input  wire               rst_n,
    cc_branch_unit_if.slave   br_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_n;
    logic                  r_z;
    logic                  r_p;
    logic                  r_ben;

    logic [DATA_W-1:0]     r_pc_snap;
    logic [OFFSET_W-1:0]   r_off_snap;
    logic                  r_ben_snap;

    logic [DATA_W-1:0]     r_pc_next;
    logic                  r_br_taken;
    logic [CNT_W-1:0]      r_taken_count;

    logic                  w_bus_zero;
    logic                  w_ben_new;
    logic                  w_capture;
    logic [DATA_W-1:0]     w_offset_sext;
    logic [DATA_W-1:0]     w_target;
    logic                  w_unused_ir;

    assign w_bus_zero    = (br_if.BUS == '0);
    assign w_ben_new     = |(br_if.IR[11:9] & {r_n, r_z, r_p});
    assign w_capture     = (r_state == S_IDLE) && br_if.br_start;
    assign w_offset_sext = {{(DATA_W-OFFSET_W){r_off_snap[OFFSET_W-1]}}, r_off_snap};
    assign w_target      = r_pc_snap + w_offset_sext;
    assign w_unused_ir   = ^br_if.IR[DATA_W-1:12];

    // BEN samples the NZP held before this edge, so a same-cycle LD_CC is invisible to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_n, r_z, r_p} <= NZP_RESET;
            r_ben           <= 1'b0;
        end else begin
            if (br_if.LD_CC) begin
                r_n <= br_if.BUS[DATA_W-1];
                r_z <= w_bus_zero;
                r_p <= !br_if.BUS[DATA_W-1] && !w_bus_zero;
            end
            if (br_if.LD_BEN) begin
                r_ben <= w_ben_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (br_if.br_start) w_state_next = S_CALC;
            S_CALC:  w_state_next = S_HOLD;
            S_HOLD:  if (br_if.br_ack) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Snapshot isolates the in-flight resolution from later PC/IR/BEN changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_snap  <= '0;
            r_off_snap <= '0;
            r_ben_snap <= 1'b0;
        end else if (w_capture) begin
            r_pc_snap  <= br_if.PC;
            r_off_snap <= br_if.IR[OFFSET_W-1:0];
            r_ben_snap <= r_ben;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_next     <= '0;
            r_br_taken    <= 1'b0;
            r_taken_count <= '0;
        end else if (r_state == S_CALC) begin
            r_pc_next  <= r_ben_snap ? w_target : r_pc_snap;
            r_br_taken <= r_ben_snap;
            if (r_ben_snap && (r_taken_count != {CNT_W{1'b1}})) begin
                r_taken_count <= r_taken_count + CNT_W'(1);
            end
        end
    end

    assign br_if.N           = r_n;
    assign br_if.Z           = r_z;
    assign br_if.P           = r_p;
    assign br_if.BEN         = r_ben;
    assign br_if.br_busy     = (r_state != S_IDLE);
    assign br_if.pc_valid    = (r_state == S_HOLD);
    assign br_if.pc_next     = r_pc_next;
    assign br_if.br_taken    = r_br_taken;
    assign br_if.taken_count = r_taken_count;

endmodule
`default_nettype wire

// File: tb/tb_cc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_cc_branch_unit
// Brief   : Directed bench for cc_branch_unit with a transaction-level model;
//           a second narrow-counter instance exercises counter saturation.
// Revision: 1.0  initial release
// ============================================================================
module tb_cc_branch_unit;

    logic clk;
    logic rst_n;

    cc_branch_unit_if #(.DATA_W(16), .CNT_W(16)) ifm ();
    cc_branch_unit_if #(.DATA_W(16), .CNT_W(2))  ifs ();

    cc_branch_unit #(.DATA_W(16), .OFFSET_W(9), .CNT_W(16), .NZP_RESET(3'b010)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .br_if (ifm)
    );

    cc_branch_unit #(.DATA_W(16), .OFFSET_W(9), .CNT_W(2), .NZP_RESET(3'b010)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .br_if (ifs)
    );

    assign ifs.BUS      = ifm.BUS;
    assign ifs.IR       = ifm.IR;
    assign ifs.PC       = ifm.PC;
    assign ifs.LD_CC    = ifm.LD_CC;
    assign ifs.LD_BEN   = ifm.LD_BEN;
    assign ifs.br_start = ifm.br_start;
    assign ifs.br_ack   = ifm.br_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int valid_rises = 0;
    logic prev_valid = 1'b0;
    logic cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: branch lifecycle tracked as a phase number (0 idle, 1 compute, 2 offered).
    logic [2:0]  m_nzp;
    logic        m_ben;
    int          m_phase;
    logic [15:0] m_pc_s;
    int          m_off_s;
    logic        m_ben_s;
    logic [15:0] m_pc_next;
    logic        m_taken;
    int          m_cnt;
    int          m_cnt_small;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_nzp = 3'b010; m_ben = 1'b0; m_phase = 0;
            m_pc_next = 16'h0; m_taken = 1'b0; m_cnt = 0; m_cnt_small = 0;
        end else begin
            int s;
            logic [2:0] old_nzp;
            old_nzp = m_nzp;
            if (ifm.LD_BEN) m_ben = (ifm.IR[11:9] & old_nzp) != 3'b000;
            if (ifm.LD_CC) begin
                if ($signed(ifm.BUS) < 0)       m_nzp = 3'b100;
                else if ($signed(ifm.BUS) == 0) m_nzp = 3'b010;
                else                            m_nzp = 3'b001;
            end
            if (m_phase == 0) begin
                if (ifm.br_start) begin
                    m_pc_s  = ifm.PC;
                    m_off_s = ifm.IR[8] ? int'(ifm.IR[8:0]) - 512 : int'(ifm.IR[8:0]);
                    m_ben_s = old_ben_for_snap(m_ben, ifm.LD_BEN, old_nzp);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                s = (int'(m_pc_s) + m_off_s) & 32'hFFFF;
                m_pc_next = m_ben_s ? s[15:0] : m_pc_s;
                m_taken   = m_ben_s;
                if (m_ben_s) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt_small < 3) m_cnt_small++;
                end
                m_phase = 2;
            end else begin
                if (ifm.br_ack) m_phase = 0;
            end
        end
    end

    logic m_ben_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_ben_prev <= 1'b0;
        else        m_ben_prev <= m_ben;
    end

    // The snapshot takes the BEN value held before the edge, not one loaded at it.
    function automatic logic old_ben_for_snap(input logic ben_now, input logic ld, input logic [2:0] nzp);
        if (ld) return m_ben_prev;
        return ben_now;
    endfunction

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("N",         ifm.N,           m_nzp[2]);
            chk("Z",         ifm.Z,           m_nzp[1]);
            chk("P",         ifm.P,           m_nzp[0]);
            chk("BEN",       ifm.BEN,         m_ben);
            chk("br_busy",   ifm.br_busy,     m_phase != 0);
            chk("pc_valid",  ifm.pc_valid,    m_phase == 2);
            chk("pc_next",   ifm.pc_next,     m_pc_next);
            chk("br_taken",  ifm.br_taken,    m_taken);
            chk("count",     ifm.taken_count, m_cnt[15:0]);
            chk("count_sat", ifs.taken_count, m_cnt_small[1:0]);
        end
        if (ifm.pc_valid && !prev_valid) valid_rises++;
        prev_valid = ifm.pc_valid;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (ifm.pc_valid) break;
            tick();
        end
        chk("pc_valid_timeout", ifm.pc_valid, 1'b1);
    endtask

    task automatic ld_cc(input logic [15:0] v);
        ifm.BUS = v; ifm.LD_CC = 1'b1; tick(); ifm.LD_CC = 1'b0;
    endtask

    task automatic ld_ben(input logic [15:0] ir);
        ifm.IR = ir; ifm.LD_BEN = 1'b1; tick(); ifm.LD_BEN = 1'b0;
    endtask

    task automatic branch(input logic [15:0] pc, input logic [15:0] ir);
        ifm.PC = pc; ifm.IR = ir; ifm.br_start = 1'b1; tick(); ifm.br_start = 1'b0;
        wait_valid(6);
        ifm.br_ack = 1'b1; tick(); ifm.br_ack = 1'b0;
    endtask

    initial begin
        int rises0;
        rst_n = 1'b0;
        ifm.BUS = '0; ifm.IR = '0; ifm.PC = '0;
        ifm.LD_CC = 1'b0; ifm.LD_BEN = 1'b0; ifm.br_start = 1'b0; ifm.br_ack = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        cmp_en = 1'b1;
        chk("rst_nzp",   {ifm.N, ifm.Z, ifm.P}, 3'b010);
        chk("rst_ben",   ifm.BEN, 1'b0);
        chk("rst_valid", ifm.pc_valid, 1'b0);
        chk("rst_count", ifm.taken_count, 16'h0);

        ld_cc(16'h8000); chk("nzp_neg",  {ifm.N, ifm.Z, ifm.P}, 3'b100);
        ld_cc(16'h0000); chk("nzp_zero", {ifm.N, ifm.Z, ifm.P}, 3'b010);
        ld_cc(16'h0001); chk("nzp_pos",  {ifm.N, ifm.Z, ifm.P}, 3'b001);

        ld_ben(16'h0E05); chk("ben_nzp", ifm.BEN, 1'b1);
        ld_ben(16'h0805); chk("ben_n",   ifm.BEN, 1'b0);
        ifm.BUS = 16'h0000; ifm.LD_CC = 1'b1; ifm.IR = 16'h0405; ifm.LD_BEN = 1'b1;
        tick(); ifm.LD_CC = 1'b0; ifm.LD_BEN = 1'b0;
        chk("ben_old_nzp", ifm.BEN, 1'b0);
        chk("nzp_after",   {ifm.N, ifm.Z, ifm.P}, 3'b010);
        ld_ben(16'h0405); chk("ben_z", ifm.BEN, 1'b1);

        // Taken branch, offset -2, with latency and stall checks.
        ifm.PC = 16'h3001; ifm.IR = 16'h0FFE; ifm.br_start = 1'b1; tick(); ifm.br_start = 1'b0;
        ifm.PC = 16'h1234; ifm.IR = 16'h0000;
        chk("lat_calc_valid", ifm.pc_valid, 1'b0);
        chk("lat_calc_busy",  ifm.br_busy, 1'b1);
        tick();
        chk("lat_hold_valid", ifm.pc_valid, 1'b1);
        chk("taken_pc",       ifm.pc_next, 16'h2FFF);
        chk("taken_flag",     ifm.br_taken, 1'b1);
        chk("taken_count1",   ifm.taken_count, 16'h1);
        repeat (4) tick();
        chk("stall_pc",       ifm.pc_next, 16'h2FFF);
        ifm.br_ack = 1'b1; tick(); ifm.br_ack = 1'b0;
        chk("ack_idle",       ifm.br_busy, 1'b0);
        chk("ack_valid",      ifm.pc_valid, 1'b0);
        chk("pc_held",        ifm.pc_next, 16'h2FFF);

        // Not-taken branch; ack in the first offered cycle.
        ld_ben(16'h0805);
        branch(16'h3005, 16'h0FFE);
        chk("nt_pc",    ifm.pc_next, 16'h3005);
        chk("nt_flag",  ifm.br_taken, 1'b0);
        chk("nt_count", ifm.taken_count, 16'h1);

        ld_ben(16'h0405);
        branch(16'hFFFF, 16'h0E01);
        chk("wrap_pc",  ifm.pc_next, 16'h0000);

        // br_start held through CALC/HOLD must yield a single offer.
        rises0 = valid_rises;
        ifm.PC = 16'h0100; ifm.IR = 16'h0E10; ifm.br_start = 1'b1;
        repeat (4) tick();
        ifm.br_ack = 1'b1; ifm.br_start = 1'b0; tick(); ifm.br_ack = 1'b0;
        repeat (3) tick();
        chk("single_offer", valid_rises - rises0, 1);
        chk("rep_pc",       ifm.pc_next, 16'h0110);
        chk("rep_count",    ifm.taken_count, 16'h3);

        branch(16'h0200, 16'h0E00);
        chk("sat_small", ifs.taken_count, 2'b11);
        chk("count4",    ifm.taken_count, 16'h4);

        // Asynchronous reset in the middle of an offer.
        ifm.PC = 16'h4000; ifm.IR = 16'h0E08; ifm.br_start = 1'b1; tick(); ifm.br_start = 1'b0;
        wait_valid(6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_nzp",   {ifm.N, ifm.Z, ifm.P}, 3'b010);
        chk("arst_ben",   ifm.BEN, 1'b0);
        chk("arst_valid", ifm.pc_valid, 1'b0);
        chk("arst_busy",  ifm.br_busy, 1'b0);
        chk("arst_pc",    ifm.pc_next, 16'h0);
        chk("arst_count", ifm.taken_count, 16'h0);
        tick();
        rst_n = 1'b1;
        rises0 = valid_rises;
        repeat (4) tick();
        chk("no_offer_after_rst", valid_rises - rises0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
